// File: rtl/alu_ctrl_exec.sv
// alu_ctrl_exec: execute-stage ALU control decode, ALU evaluation and one-cycle result register.
// Optional signed-overflow flag V is built only when ALU_OVF_EN is defined.
module alu_ctrl_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] Data_A,
  input  logic [WIDTH-1:0] Data_B,
  output logic             out_valid,
  output logic [WIDTH-1:0] Z,
  output logic [5:0]       ALUFun,
  output logic             Sign,
  output logic             V
);
  localparam logic [5:0] F_ADD = 6'b000000, F_SUB = 6'b000001, F_AND = 6'b011000,
                         F_OR  = 6'b011110, F_XOR = 6'b010110, F_NOR = 6'b010001,
                         F_SLL = 6'b100000, F_SRL = 6'b100001, F_SRA = 6'b100011,
                         F_EQ  = 6'b110011, F_NEQ = 6'b110001, F_LT  = 6'b110101,
                         F_LEZ = 6'b111101, F_GTZ = 6'b111111, F_LTZ = 6'b111011;
  logic [5:0]       fun_d, fun_q;
  logic             sign_d, sign_q, valid_q, lt;
  logic [WIDTH-1:0] z_d, z_q, sum, diff;
  always_comb begin
    fun_d = F_ADD;
    if (OpCode == 6'h00) begin
      case (Funct)
        6'h22, 6'h23: fun_d = F_SUB;
        6'h24:        fun_d = F_AND;
        6'h25:        fun_d = F_OR;
        6'h26:        fun_d = F_XOR;
        6'h27:        fun_d = F_NOR;
        6'h00:        fun_d = F_SLL;
        6'h02:        fun_d = F_SRL;
        6'h03:        fun_d = F_SRA;
        6'h2a, 6'h2b: fun_d = F_LT;
        default:      fun_d = F_ADD;
      endcase
    end else begin
      case (OpCode)
        6'h0c:        fun_d = F_AND;
        6'h0a, 6'h0b: fun_d = F_LT;
        6'h04:        fun_d = F_EQ;
        6'h05:        fun_d = F_NEQ;
        6'h06:        fun_d = F_LEZ;
        6'h07:        fun_d = F_GTZ;
        6'h01:        fun_d = F_LTZ;
        default:      fun_d = F_ADD;
      endcase
    end
  end
  // Unsigned variants: addu, subu, sltu, addiu, sltiu
  assign sign_d = !((OpCode == 6'h00 && (Funct == 6'h21 || Funct == 6'h23 || Funct == 6'h2b)) ||
                    OpCode == 6'h09 || OpCode == 6'h0b);
  assign sum  = Data_A + Data_B;
  assign diff = Data_A - Data_B;
  assign lt   = sign_d ? ($signed(Data_A) < $signed(Data_B)) : (Data_A < Data_B);
  always_comb begin
    z_d = '0;
    case (fun_d)
      F_ADD:   z_d = sum;
      F_SUB:   z_d = diff;
      F_AND:   z_d = Data_A & Data_B;
      F_OR:    z_d = Data_A | Data_B;
      F_XOR:   z_d = Data_A ^ Data_B;
      F_NOR:   z_d = ~(Data_A | Data_B);
      F_SLL:   z_d = Data_B << Data_A[4:0];
      F_SRL:   z_d = Data_B >> Data_A[4:0];
      F_SRA:   z_d = $signed(Data_B) >>> Data_A[4:0];
      F_EQ:    z_d = {{(WIDTH-1){1'b0}}, Data_A == Data_B};
      F_NEQ:   z_d = {{(WIDTH-1){1'b0}}, Data_A != Data_B};
      F_LT:    z_d = {{(WIDTH-1){1'b0}}, lt};
      F_LEZ:   z_d = {{(WIDTH-1){1'b0}}, Data_A[WIDTH-1] || Data_A == '0};
      F_GTZ:   z_d = {{(WIDTH-1){1'b0}}, !Data_A[WIDTH-1] && Data_A != '0};
      F_LTZ:   z_d = {{(WIDTH-1){1'b0}}, Data_A[WIDTH-1]};
      default: z_d = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_q     <= '0;
      fun_q   <= '0;
      sign_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      z_q     <= z_d;
      fun_q   <= fun_d;
      sign_q  <= sign_d;
      valid_q <= in_valid;
    end
  end
`ifdef ALU_OVF_EN
  logic v_d, v_q;
  assign v_d = sign_d &&
    ((fun_d == F_ADD && Data_A[WIDTH-1] == Data_B[WIDTH-1] && sum[WIDTH-1] != Data_A[WIDTH-1]) ||
     (fun_d == F_SUB && Data_A[WIDTH-1] != Data_B[WIDTH-1] && diff[WIDTH-1] != Data_A[WIDTH-1]));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) v_q <= 1'b0;
    else        v_q <= v_d;
  end
  assign V = v_q;
`else
  assign V = 1'b0;
`endif
  assign Z         = z_q;
  assign ALUFun    = fun_q;
  assign Sign      = sign_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_alu_ctrl_exec.sv
// tb_alu_ctrl_exec: directed vectors with a queue scoreboard checked by an independent monitor.
module tb_alu_ctrl_exec;
  typedef struct packed {
    logic [31:0] z;
    logic [5:0]  fun;
    logic        sign;
    logic        v;
  } exp_t;
  logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0;
  logic [5:0]  OpCode = '0, Funct = '0;
  logic [31:0] Data_A = '0, Data_B = '0;
  logic        out_valid, Sign, V;
  logic [31:0] Z;
  logic [5:0]  ALUFun;
  exp_t        q[$];
  int          checks = 0, errors = 0;
`ifdef ALU_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif
  alu_ctrl_exec #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .OpCode(OpCode), .Funct(Funct),
    .Data_A(Data_A), .Data_B(Data_B), .out_valid(out_valid), .Z(Z), .ALUFun(ALUFun),
    .Sign(Sign), .V(V)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (out_valid) begin
      exp_t act, e;
      act = '{Z, ALUFun, Sign, V};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got Z=%h ALUFun=%b Sign=%b V=%b with empty scoreboard",
                 Z, ALUFun, Sign, V);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL result got Z=%h ALUFun=%b Sign=%b V=%b expected Z=%h ALUFun=%b Sign=%b V=%b",
                   act.z, act.fun, act.sign, act.v, e.z, e.fun, e.sign, e.v);
        end
      end
    end
  end
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] z, input logic [5:0] fun,
                       input logic sg, input logic v);
    @(negedge clk);
    in_valid = 1'b1;
    OpCode = op;
    Funct = fn;
    Data_A = a;
    Data_B = b;
    q.push_back('{z, fun, sg, v});
  endtask
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    OpCode = 6'h3f;
    Funct = 6'h3f;
  endtask
  task automatic check_zero(input string name);
    checks++;
    if ({Z, ALUFun, Sign, V, out_valid} !== '0) begin
      errors++;
      $display("FAIL %s got Z=%h ALUFun=%b Sign=%b V=%b out_valid=%b expected all zero",
               name, Z, ALUFun, Sign, V, out_valid);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b1;
    issue(6'h00, 6'h20, 32'd7, 32'd9, 32'd16, 6'b000000, 1'b1, 1'b0);
    issue(6'h00, 6'h22, 32'd7, 32'd9, 32'hfffffffe, 6'b000001, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    #2 reset = 1'b0;
    #1 check_zero("reset_midstream");
    q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1 check_zero("reset_held");
    @(negedge clk);
    reset = 1'b1;
    issue(6'h00, 6'h20, 32'd3, 32'd5, 32'd8, 6'b000000, 1'b1, 1'b0);
    issue(6'h09, 6'h00, 32'h7fffffff, 32'd5, 32'h80000004, 6'b000000, 1'b0, 1'b0);
    issue(6'h08, 6'h00, 32'h7fffffff, 32'd5, 32'h80000004, 6'b000000, 1'b1, OVF);
    issue(6'h00, 6'h23, 32'hfffffffb, 32'hfffffffd, 32'hfffffffe, 6'b000001, 1'b0, 1'b0);
    issue(6'h00, 6'h22, 32'h80000000, 32'd1, 32'h7fffffff, 6'b000001, 1'b1, OVF);
    issue(6'h2b, 6'h00, 32'd0, 32'h9fc30000, 32'h9fc30000, 6'b000000, 1'b1, 1'b0);
    idle();
    issue(6'h00, 6'h24, 32'ha85e9cd0, 32'h2ec90029, 32'h28480000, 6'b011000, 1'b1, 1'b0);
    issue(6'h00, 6'h25, 32'ha85e9cd0, 32'h2ec90029, 32'haedf9cf9, 6'b011110, 1'b1, 1'b0);
    issue(6'h00, 6'h26, 32'ha85e9cd0, 32'h2ec90029, 32'h86979cf9, 6'b010110, 1'b1, 1'b0);
    issue(6'h00, 6'h27, 32'ha85e9cd0, 32'h2ec90029, 32'h51206306, 6'b010001, 1'b1, 1'b0);
    issue(6'h0c, 6'h27, 32'ha85e9cd0, 32'h2ec90029, 32'h28480000, 6'b011000, 1'b1, 1'b0);
    issue(6'h00, 6'h2a, 32'hfffffffb, 32'd3, 32'd1, 6'b110101, 1'b1, 1'b0);
    issue(6'h00, 6'h2b, 32'hfffffffb, 32'd3, 32'd0, 6'b110101, 1'b0, 1'b0);
    issue(6'h0b, 6'h00, 32'd3, 32'hfffffffb, 32'd1, 6'b110101, 1'b0, 1'b0);
    issue(6'h0a, 6'h00, 32'd3, 32'hfffffffb, 32'd0, 6'b110101, 1'b1, 1'b0);
    issue(6'h06, 6'h00, 32'hc672e58a, 32'd0, 32'd1, 6'b111101, 1'b1, 1'b0);
    issue(6'h07, 6'h00, 32'hc672e58a, 32'd0, 32'd0, 6'b111111, 1'b1, 1'b0);
    issue(6'h01, 6'h00, 32'hc672e58a, 32'd0, 32'd1, 6'b111011, 1'b1, 1'b0);
    issue(6'h07, 6'h00, 32'h5672e58a, 32'd0, 32'd1, 6'b111111, 1'b1, 1'b0);
    issue(6'h06, 6'h00, 32'd0, 32'd7, 32'd1, 6'b111101, 1'b1, 1'b0);
    issue(6'h04, 6'h00, 32'hfe8b67a4, 32'hfe8b67a4, 32'd1, 6'b110011, 1'b1, 1'b0);
    issue(6'h05, 6'h00, 32'hfe8b67a4, 32'hfe8b67a4, 32'd0, 6'b110001, 1'b1, 1'b0);
    issue(6'h00, 6'h00, 32'd4, 32'h80000010, 32'h00000100, 6'b100000, 1'b1, 1'b0);
    issue(6'h00, 6'h02, 32'd4, 32'h80000010, 32'h08000001, 6'b100001, 1'b1, 1'b0);
    issue(6'h00, 6'h03, 32'd4, 32'h80000010, 32'hf8000001, 6'b100011, 1'b1, 1'b0);
    issue(6'h00, 6'h3f, 32'd4, 32'h80000010, 32'h80000014, 6'b000000, 1'b1, 1'b0);
    issue(6'h00, 6'h08, 32'h00400000, 32'd0, 32'h00400000, 6'b000000, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    #1 checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding results expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_exec.md
Name: alu_ctrl_exec

Overview:
- Execute-stage slice of the pipelined MIPS-subset CPU.
- Decodes OpCode/Funct into the 6-bit ALUFun code and a Sign flag, then evaluates the ALU on Data_A/Data_B.
- Registers the result: one cycle of latency, with a valid qualifier.
- Sits between the ID/EX register and the EX/MEM register.

Parameters:
- WIDTH, 32, datapath width in bits; only 32 is supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  the OpCode/Funct/Data qualifiers this cycle are valid.
- OpCode  input  6  instruction[31:26].
- Funct  input  6  instruction[5:0]; used only when OpCode = 6'h00.
- Data_A  input  32  operand A (rs; shamt for shifts, in A[4:0]).
- Data_B  input  32  operand B (rt or extended immediate).
- out_valid  output  1  Z/ALUFun/Sign/V hold a valid result.
- Z  output  32  registered ALU result.
- ALUFun  output  6  registered decoded ALU function.
- Sign  output  1  registered signedness flag.
- V  output  1  registered signed overflow flag.

Behaviour:
- Reset (reset=0, asynchronous): Z=0, ALUFun=0, Sign=0, V=0, out_valid=0.
- Outputs hold 0 until the first clk edge after reset deasserts.

Control decode (combinational). OpCode 6'h00, by Funct:
- 20 add, 21 addu, 08 jr, anything else -> ADD 000000.
- 22 sub, 23 subu -> SUB 000001.
- 24 and -> AND 011000. 25 or -> OR 011110. 26 xor -> XOR 010110. 27 nor -> NOR 010001.
- 00 sll -> SLL 100000. 02 srl -> SRL 100001. 03 sra -> SRA 100011.
- 2a slt -> LT 110101. 2b sltu -> LT 110101.

Other opcodes (Funct ignored):
- 08 addi, 09 addiu, 0f lui, 23 lw, 2b sw, 02 j, 03 jal, any undefined opcode -> ADD.
- 0c andi -> AND.
- 0a slti, 0b sltiu -> LT.
- 04 beq -> EQ 110011. 05 bne -> NEQ 110001.
- 06 blez -> LEZ 111101. 07 bgtz -> GTZ 111111. 01 bltz -> LTZ 111011.

Sign:
- Sign=0 for sltu (00/2b) and sltiu (0b).
- Sign=0 for addu, subu, addiu.
- Sign=1 otherwise.

ALU (combinational):
- ADD: A+B mod 2^32. SUB: A-B mod 2^32.
- Logic ops are bitwise.
- SLL: B<<A[4:0]. SRL: logical right shift of B by A[4:0]. SRA: arithmetic right shift of B by A[4:0].
- Compare ops return {31'b0, flag}.
  - EQ: A==B. NEQ: A!=B.
  - LT: A<B, signed if Sign=1, unsigned if Sign=0.
  - LEZ: A signed <=0. GTZ: A signed >0. LTZ: A[31]. LEZ/GTZ/LTZ ignore B.
- Any undefined ALUFun code -> Z=0.

Register stage (every clk edge, regardless of in_valid):
- Z, ALUFun and Sign capture the decode/ALU values.
- out_valid <= in_valid.
- Exactly 1-cycle latency, no stall or back-pressure.
- A reset asserted mid-stream clears everything immediately; the next result appears 1 cycle after the first post-reset edge.

Optional Feature:
- ALU_OVF_EN defined:
  - V <= 1 when Sign=1 and ALUFun is ADD/SUB with signed overflow: operands of the same sign for ADD, or of differing sign for SUB, and the result sign differs from A.
  - Otherwise V <= 0.
- ALU_OVF_EN undefined: V is constant 0 and no overflow logic is built.

Test Plan:
- Reset low mid-operation -> Z=0, out_valid=0 immediately; release, then in_valid=1, OpCode=00 Funct=20, A=3, B=5 -> next cycle Z=8, out_valid=1.
- Add/sub family:
  - addiu (09), A=32'h7fffffff, B=5 -> Z=32'h80000004, V=0.
  - addi (08), same operands -> Z=32'h80000004, V=1 (with ALU_OVF_EN).
  - subu (23), A=-5, B=-3 -> Z=-2.
  - lui via sw opcode 2b, A=0, B=32'h9fc30000 -> Z=32'h9fc30000.
- Logic, A=32'ha85e9cd0, B=32'h2ec90029:
  - and -> 32'h28480000.
  - or -> 32'haedf9cf9.
  - xor -> 32'h86979cf9.
  - nor -> 32'h51206306.
  - andi (0c) -> 32'h28480000.
- Compares:
  - slt, A=-5, B=3 -> 1.
  - sltu, A=-5, B=3 -> 0.
  - sltiu, A=3, B=-5 -> 1.
  - slti, A=3, B=-5 -> 0.
- Branches with A=32'hc672e58a, B=0:
  - blez -> 1. bgtz -> 0. bltz -> 1.
  - bgtz with A=32'h5672e58a -> 1.
  - beq with equal operands 32'hfe8b67a4 -> 1.
  - bne with the same operands -> 0.
- Shifts, B=32'h80000010:
  - sll, A=4 -> 32'h00000100.
  - srl, A=4 -> 32'h08000001.
  - sra, A=4 -> 32'hf8000001.
  - Undefined Funct 6'h3f on OpCode 00 -> ADD result.
